// File: rtl/dram_slave_pkg.sv
// Shared word/lane definitions and lane-merge helper for the data RAM slave.
package dram_slave_pkg;

  localparam int InstBus = 32;
  localparam int Wordnum = InstBus;
  localparam int Lanes   = 4;

  localparam logic          Enable   = 1'b1;
  localparam logic          Disable  = 1'b0;
  localparam logic [31:0]   ZeroWord = 32'h0000_0000;

  // Array port usage in a given cycle.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_DRAIN = 2'd2
  } arr_op_e;

  // Per-lane select: take the byte from upd where be is set, else from base.
  function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                              input logic [31:0] upd,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int i = 0; i < Lanes; i++) begin
      res[8*i +: 8] = be[i] ? upd[8*i +: 8] : base[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dram_slave_ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables and registered
// read data. Storage is deliberately not reset. Read data only updates on a
// read access, so it holds across write/idle cycles.
module ram_sp_be
  import dram_slave_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];

  // One access per cycle: byte-lane write when any we bit is set, else read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        for (int i = 0; i < Lanes; i++) begin
          if (we[i]) begin
            mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem_r[idx];
      end
    end
  end

endmodule

// File: rtl/dram_slave.sv
// Data RAM responder: one-entry posted write buffer in front of a
// single-port array, read forwarding from the buffer, sticky protocol error.
module dram_slave
  import dram_slave_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  wen,
  input  logic        ren,
  output logic [31:0] r_data,
  output logic        err
);

  logic [AW-1:0] idx_s;
  logic          wr_req_s;
  logic          hit_s;
  logic          unused_addr_bits;
  arr_op_e       op_s;

  logic          ram_en_s;
  logic [3:0]    ram_we_s;
  logic [AW-1:0] ram_idx_s;
  logic [31:0]   ram_rdata_s;

  logic          wb_valid_r;
  logic [AW-1:0] wb_idx_r;
  logic [31:0]   wb_data_r;
  logic [3:0]    wb_be_r;
  logic [31:0]   fwd_data_r;
  logic [3:0]    fwd_be_r;
  logic          rd_seen_r;
  logic          err_r;

  assign idx_s            = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
  assign wr_req_s         = |wen;
  assign hit_s            = wb_valid_r && (wb_idx_r == idx_s);

  // Arbitrate the array port: core read first, then buffer drain when the
  // buffer is not about to absorb a same-word write.
  always_comb begin
    op_s = OP_IDLE;
    if (ren) begin
      op_s = OP_READ;
    end else if (wb_valid_r && (!wr_req_s || !hit_s)) begin
      op_s = OP_DRAIN;
    end else begin
      op_s = OP_IDLE;
    end
  end

  // Drive the array port from the chosen operation.
  always_comb begin
    ram_en_s  = Disable;
    ram_we_s  = 4'b0000;
    ram_idx_s = idx_s;
    case (op_s)
      OP_READ: begin
        ram_en_s  = Enable;
        ram_we_s  = 4'b0000;
        ram_idx_s = idx_s;
      end
      OP_DRAIN: begin
        ram_en_s  = Enable;
        ram_we_s  = wb_be_r;
        ram_idx_s = wb_idx_r;
      end
      default: begin
        ram_en_s  = Disable;
        ram_we_s  = 4'b0000;
        ram_idx_s = idx_s;
      end
    endcase
  end

  ram_sp_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .idx   (ram_idx_s),
    .wdata (wb_data_r),
    .rdata (ram_rdata_s)
  );

  // Posted write buffer: capture, same-word merge, or release after drain.
  // A write alongside a read is illegal and is dropped here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid_r <= 1'b0;
      wb_idx_r   <= '0;
      wb_data_r  <= ZeroWord;
      wb_be_r    <= 4'b0000;
    end else if (!ren && wr_req_s) begin
      if (hit_s) begin
        wb_data_r <= merge_lanes(wb_data_r, w_data, wen);
        wb_be_r   <= wb_be_r | wen;
      end else begin
        wb_valid_r <= 1'b1;
        wb_idx_r   <= idx_s;
        wb_data_r  <= w_data;
        wb_be_r    <= wen;
      end
    end else if (op_s == OP_DRAIN) begin
      wb_valid_r <= 1'b0;
    end
  end

  // Forward pair sampled with each read so buffered bytes override the
  // array's stale copy; held with the read data until the next read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fwd_data_r <= ZeroWord;
      fwd_be_r   <= 4'b0000;
      rd_seen_r  <= 1'b0;
    end else if (ren) begin
      fwd_data_r <= wb_data_r;
      fwd_be_r   <= hit_s ? wb_be_r : 4'b0000;
      rd_seen_r  <= 1'b1;
    end
  end

  // Sticky protocol error on simultaneous read and write request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 1'b0;
    end else if (ren && wr_req_s) begin
      err_r <= 1'b1;
    end
  end

  // Final read word: zero until the first read after reset, since the
  // array's read register has no reset.
  always_comb begin
    r_data = ZeroWord;
    if (rd_seen_r) begin
      r_data = merge_lanes(ram_rdata_s, fwd_data_r, fwd_be_r);
    end else begin
      r_data = ZeroWord;
    end
  end

  assign err = err_r;

endmodule

// File: tb/tb_dram_slave.sv
// Directed, table-driven bench for dram_slave.
module tb_dram_slave;

  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [3:0]  wen;
  logic        ren;
  logic [31:0] r_data;
  logic        err;

  int checks;
  int errors;

  typedef struct {
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  dram_slave #(.DEPTH(4096), .AW(12)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .addr   (addr),
    .w_data (w_data),
    .wen    (wen),
    .ren    (ren),
    .r_data (r_data),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addv(input logic r, input logic [3:0] w, input logic [31:0] a,
                               input logic [31:0] d, input logic c, input logic [31:0] e,
                               input logic ee);
    vec_t v;
    v.ren = r; v.wen = w; v.addr = a; v.wdata = d;
    v.chk = c; v.exp_data = e; v.exp_err = ee;
    vq.push_back(v);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; addr = a; w_data = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    rstn = 1'b0;

    // ren, wen, addr, wdata, check r_data, expected r_data, expected err
    addv(1'b0, 4'b1111, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        1'b0); // capture
    addv(1'b1, 4'b0000, 32'h10,   32'h0,        1'b1, 32'hDEADBEEF, 1'b0); // forwarded
    addv(1'b0, 4'b0000, 32'h0,    32'h0,        1'b1, 32'hDEADBEEF, 1'b0); // drain, held
    addv(1'b1, 4'b0000, 32'h10,   32'h0,        1'b1, 32'hDEADBEEF, 1'b0); // from array
    addv(1'b1, 4'b0000, 32'h4010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0); // alias
    addv(1'b0, 4'b1111, 32'h20,   32'h11223344, 1'b0, 32'h0,        1'b0);
    addv(1'b0, 4'b0000, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0);
    addv(1'b0, 4'b0100, 32'h20,   32'h00AA0000, 1'b0, 32'h0,        1'b0);
    addv(1'b1, 4'b0000, 32'h20,   32'h0,        1'b1, 32'h11AA3344, 1'b0); // partial fwd
    addv(1'b0, 4'b1111, 32'h30,   32'h12345678, 1'b0, 32'h0,        1'b0);
    addv(1'b0, 4'b0000, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0);
    addv(1'b0, 4'b0001, 32'h30,   32'h00000055, 1'b0, 32'h0,        1'b0);
    addv(1'b0, 4'b1000, 32'h30,   32'h66000000, 1'b0, 32'h0,        1'b0); // merge
    addv(1'b1, 4'b0000, 32'h30,   32'h0,        1'b1, 32'h66345655, 1'b0);
    addv(1'b0, 4'b1111, 32'h40,   32'hA5A5A5A5, 1'b1, 32'h66345655, 1'b0); // hold
    addv(1'b0, 4'b1111, 32'h44,   32'h5A5A5A5A, 1'b1, 32'h66345655, 1'b0); // drain+capture
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) addv(1'b1, 4'b0000, 32'h40, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0);
      else            addv(1'b1, 4'b0000, 32'h44, 32'h0, 1'b1, 32'h5A5A5A5A, 1'b0);
    end
    addv(1'b0, 4'b0000, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0);
    addv(1'b1, 4'b0000, 32'h40,   32'h0,        1'b1, 32'hA5A5A5A5, 1'b0);
    addv(1'b1, 4'b0000, 32'h44,   32'h0,        1'b1, 32'h5A5A5A5A, 1'b0);
    addv(1'b0, 4'b1111, 32'h50,   32'h0BADF00D, 1'b0, 32'h0,        1'b0);
    addv(1'b0, 4'b0000, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0);
    addv(1'b1, 4'b1111, 32'h50,   32'hFFFFFFFF, 1'b1, 32'h0BADF00D, 1'b1); // illegal
    addv(1'b0, 4'b0000, 32'h0,    32'h0,        1'b1, 32'h0BADF00D, 1'b1);
    addv(1'b1, 4'b0000, 32'h50,   32'h0,        1'b1, 32'h0BADF00D, 1'b1); // unchanged
    addv(1'b0, 4'b1111, 32'h60,   32'h13579BDF, 1'b0, 32'h0,        1'b1);
    addv(1'b0, 4'b0000, 32'h0,    32'h0,        1'b0, 32'h0,        1'b1);
    addv(1'b0, 4'b1111, 32'h60,   32'hFFFFFFFF, 1'b0, 32'h0,        1'b1); // buffered

    repeat (3) @(posedge clk);
    #1;
    check32("reset r_data", r_data, 32'h0);
    check1("reset err", err, 1'b0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ren, vq[i].wen, vq[i].addr, vq[i].wdata);
      @(posedge clk);
      #1;
      if (vq[i].chk) check32($sformatf("vec%0d r_data", i), r_data, vq[i].exp_data);
      check1($sformatf("vec%0d err", i), err, vq[i].exp_err);
    end

    // Reset with the buffer holding a write to 0x60: the write is lost.
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    rstn = 1'b0;
    #1;
    check32("midreset r_data", r_data, 32'h0);
    check1("midreset err", err, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check32("postreset hold r_data", r_data, 32'h0);
    drive(1'b1, 4'b0000, 32'h60, 32'h0);
    @(posedge clk);
    #1;
    check32("postreset read 0x60", r_data, 32'h13579BDF);
    check1("postreset err", err, 1'b0);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check32("postreset read held", r_data, 32'h13579BDF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
